rotate_sequencer: RTL and testbench

ROTATE_SEQUENCER -- requirements
Module: rotate_sequencer

---
 rtl/rotate_sequencer.sv | 88 ++++++++
 tb/tb_rotate_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rotate_sequencer.sv
// Sequencer that loads a pattern into a downstream left-rotator, then drives
// it through a counted number of rotations, keeping a shadow copy in exp_q.
module rotate_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  r_l,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] exp_q
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROTATE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] pat_l;
    logic [CNT_WIDTH-1:0]  cnt_l;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            exp_q     <= '0;
            remaining <= '0;
            pat_l     <= '0;
            cnt_l     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_l <= pattern;
                        cnt_l <= count;
                    end
                end
                LOAD: begin
                    exp_q     <= pat_l;
                    remaining <= cnt_l;
                end
                ROTATE: begin
                    exp_q     <= {exp_q[DATA_WIDTH-2:0], exp_q[DATA_WIDTH-1]};
                    remaining <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = (abort || cnt_l == '0) ? DONE : ROTATE;
            // the rotation on the exiting edge still happens in the register block
            ROTATE:  if (abort || remaining == CNT_WIDTH'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r_l   = 1'b0;
        ready = 1'b0;
        done  = 1'b0;
        data  = exp_q;
        case (state)
            IDLE:    ready = 1'b1;
            LOAD:    data  = pat_l;
            ROTATE:  r_l   = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer: directed table, corner sequences,
// and randomized jobs against a transaction-level reference model.
module tb_rotate_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] count;
    logic       abort;
    logic [7:0] data;
    logic       r_l;
    logic       ready;
    logic       done;
    logic [7:0] exp_q;

    int checks   = 0;
    int failures = 0;
    logic [7:0] model_q;

    rotate_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .count   (count),
        .abort   (abort),
        .data    (data),
        .r_l     (r_l),
        .ready   (ready),
        .done    (done),
        .exp_q   (exp_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        int         c;
        int         t_ab;
        int         noise;
        logic [7:0] npat;
        logic [7:0] want_q;
        int         want_done_t;
        int         want_rl;
    } vec_t;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] w_data, input logic w_rl,
                              input logic w_ready, input logic w_done, input logic [7:0] w_q);
        check({tag, ".data"},  32'(data),  32'(w_data));
        check({tag, ".r_l"},   32'(r_l),   32'(w_rl));
        check({tag, ".ready"}, 32'(ready), 32'(w_ready));
        check({tag, ".done"},  32'(done),  32'(w_done));
        check({tag, ".exp_q"}, 32'(exp_q), 32'(w_q));
    endtask

    // One job from IDLE. t counts cycles after the accept edge (t=1 is the load cycle);
    // abort is held high only during cycle t_ab (0 = never).
    task automatic run_job(input logic [7:0] p, input int c, input int t_ab,
                           input int noise, input logic [7:0] npat,
                           output int done_t, output int rl_n, output logic [7:0] fin);
        int n;
        logic [7:0] q;
        if (t_ab == 0)          n = c;
        else if (t_ab == 1)     n = 0;
        else                    n = (t_ab - 1 < c) ? t_ab - 1 : c;
        done_t = 0;
        rl_n   = 0;
        check_outs("idle", model_q, 1'b0, 1'b1, 1'b0, model_q);
        start   = 1'b1;
        pattern = p;
        count   = 4'(c);
        abort   = 1'($urandom_range(0, 1));
        step();
        for (int t = 1; t <= n + 3; t++) begin
            if (t == 1) begin
                check_outs("load", p, 1'b0, 1'b0, 1'b0, model_q);
            end else if (t <= n + 1) begin
                q = rotl(p, t - 2);
                check_outs("rotate", q, 1'b1, 1'b0, 1'b0, q);
            end else if (t == n + 2) begin
                q = rotl(p, n);
                check_outs("done", q, 1'b0, 1'b0, 1'b1, q);
            end else begin
                q = rotl(p, n);
                check_outs("back_idle", q, 1'b0, 1'b1, 1'b0, q);
            end
            if (done === 1'b1 && done_t == 0) done_t = t;
            if (r_l === 1'b1) rl_n++;
            fin = exp_q;
            if (t < n + 3) begin
                start   = (noise != 0) ? 1'b1 : 1'b0;
                pattern = npat;
                count   = 4'($urandom_range(0, 15));
                abort   = (t == t_ab) || (t == n + 2 && noise != 0);
                step();
            end
        end
        start   = 1'b0;
        abort   = 1'b0;
        model_q = rotl(p, n);
    endtask

    vec_t vecs[$];
    int dt, rn;
    logic [7:0] fq;

    initial begin
        vecs.push_back('{8'h81, 3,  0, 0, 8'h00, 8'h0C, 5,  3});
        vecs.push_back('{8'h3C, 0,  0, 0, 8'h00, 8'h3C, 2,  0});
        vecs.push_back('{8'h96, 8,  0, 0, 8'h00, 8'h96, 10, 8});
        vecs.push_back('{8'hA5, 5,  0, 1, 8'hFF, 8'hB4, 7,  5});
        vecs.push_back('{8'h01, 5,  4, 0, 8'h00, 8'h08, 5,  3});
        vecs.push_back('{8'h80, 15, 0, 0, 8'h00, 8'h40, 17, 15});
        vecs.push_back('{8'h5A, 4,  1, 0, 8'h00, 8'h5A, 2,  0});
        vecs.push_back('{8'hC3, 1,  0, 1, 8'h11, 8'h87, 3,  1});

        rst = 1'b0; start = 1'b0; pattern = '0; count = '0; abort = 1'b0;
        model_q = '0;
        #3;
        check_outs("reset", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        step();
        check_outs("reset_clk", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_job(vecs[i].p, vecs[i].c, vecs[i].t_ab, vecs[i].noise, vecs[i].npat, dt, rn, fq);
            check($sformatf("vec%0d.final_q", i),  32'(fq), 32'(vecs[i].want_q));
            check($sformatf("vec%0d.done_t", i),   32'(dt), 32'(vecs[i].want_done_t));
            check($sformatf("vec%0d.rl_cycles", i), 32'(rn), 32'(vecs[i].want_rl));
        end

        // asynchronous reset in the middle of a rotation
        start = 1'b1; pattern = 8'h01; count = 4'd6;
        step();
        start = 1'b0;
        step();
        step();
        check_outs("pre_rst", 8'h02, 1'b1, 1'b0, 1'b0, 8'h02);
        #2 rst = 1'b0;
        #1;
        check_outs("async_rst", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check_outs("rst_hold", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        rst = 1'b1;
        model_q = '0;
        run_job(8'h02, 1, 0, 0, 8'h00, dt, rn, fq);
        check("post_rst.final_q", 32'(fq), 32'h04);
        check("post_rst.done_t",  32'(dt), 32'd3);

        for (int j = 0; j < 40; j++) begin
            int c, tab, gap;
            c   = $urandom_range(0, 15);
            tab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, c + 2) : 0;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                abort = 1'($urandom_range(0, 1));
                step();
                check_outs("gap", model_q, 1'b0, 1'b1, 1'b0, model_q);
            end
            abort = 1'b0;
            run_job(8'($urandom), c, tab, $urandom_range(0, 1), 8'($urandom), dt, rn, fq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
